poker_card_dealer: RTL

- Upstream feeder for the 7-segment decoder stage (4-bit digit in, 7-bit active-low segments out) in the Indian-poker board.
- Holds a finite deck: COPIES copies of each card value 0..9.
- On request, deals two distinct draws (player A, player B) using a free-running LFSR, and presents each as a 4-bit digit ready for one decoder instance per player.
- Tracks cards remaining and flags an exhausted deck.

---
 rtl/dealer_pkg.sv | 28 ++
 rtl/dealer_lfsr8.sv | 25 ++
 rtl/poker_card_dealer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/dealer_pkg.sv
// Shared types and helpers for the poker card dealer: FSM states, card type,
// LFSR taps and the mapping from a random nibble to a card value.
package dealer_pkg;

    localparam int NUM_VALUES = 10;

    // Feedback taps for lfsr[7], lfsr[5], lfsr[4] and lfsr[3].
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef logic [3:0] card_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAW_A,
        DRAW_B,
        DONE
    } state_t;

    // Fold nibbles 10..15 onto 4..9 so every nibble maps to a valid card.
    function automatic card_t to_candidate(input logic [3:0] raw);
        return (raw < 4'd10) ? raw : raw - 4'd6;
    endfunction

    function automatic card_t next_probe(input card_t p);
        return (p == card_t'(NUM_VALUES - 1)) ? 4'd0 : p + 4'd1;
    endfunction

endpackage

// File: rtl/dealer_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR with synchronous load; a zero load value
// is replaced by 8'h01 so the register can never lock up at zero.
module dealer_lfsr8
    import dealer_pkg::*;
#(
    parameter logic [7:0] RESET_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] seed,
    output logic [7:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= RESET_SEED;
        end else if (load) begin
            value <= (seed == 8'h00) ? 8'h01 : seed;
        end else begin
            value <= {value[6:0], ^(value & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/poker_card_dealer.sv
// Poker card dealer: deck of COPIES x values 0..9, deals two cards per request.
// Optional macro DEALER_SEED_PORT_EN adds a seed input loaded into the LFSR on shuffle.
module poker_card_dealer
    import dealer_pkg::*;
#(
    parameter int         COPIES    = 2,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       shuffle,
    input  logic       deal_req,
`ifdef DEALER_SEED_PORT_EN
    input  logic [7:0] seed,
`endif
    output logic [3:0] card_a,
    output logic [3:0] card_b,
    output logic       deal_valid,
    output logic       busy,
    output logic       deal_err,
    output logic [4:0] cards_left,
    output logic       deck_empty
);

    localparam int DECK_SIZE = NUM_VALUES * COPIES;

    state_t     state;
    card_t      probe;
    card_t      card_a_next;
    card_t      cand;
    logic [2:0] count [NUM_VALUES];
    logic [6:0] left;
    logic [7:0] lfsr;
    logic [7:0] shuffle_seed;
    logic       lfsr_hi_unused;

`ifdef DEALER_SEED_PORT_EN
    assign shuffle_seed = seed;
`else
    assign shuffle_seed = LFSR_SEED;
`endif

    dealer_lfsr8 #(
        .RESET_SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (shuffle),
        .seed  (shuffle_seed),
        .value (lfsr)
    );

    assign cand           = to_candidate(lfsr[3:0]);
    assign lfsr_hi_unused = ^lfsr[7:4];

    // Large decks (COPIES > 3) exceed the 5-bit port; report saturated.
    assign cards_left = (left > 7'd31) ? 5'd31 : left[4:0];
    assign deck_empty = (left < 7'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            probe       <= '0;
            card_a_next <= '0;
            card_a      <= '0;
            card_b      <= '0;
            deal_valid  <= 1'b0;
            busy        <= 1'b0;
            deal_err    <= 1'b0;
            left        <= 7'(DECK_SIZE);
            for (int i = 0; i < NUM_VALUES; i++) begin
                count[i] <= 3'(COPIES);
            end
        end else begin
            deal_valid <= 1'b0;
            deal_err   <= 1'b0;
            if (shuffle) begin
                state <= IDLE;
                busy  <= 1'b0;
                left  <= 7'(DECK_SIZE);
                for (int i = 0; i < NUM_VALUES; i++) begin
                    count[i] <= 3'(COPIES);
                end
            end else begin
                // Entry requires >= 2 cards, so each linear probe finds a card
                // within 10 cycles without an explicit probe counter.
                case (state)
                    IDLE: begin
                        if (deal_req) begin
                            if (left >= 7'd2) begin
                                probe <= cand;
                                busy  <= 1'b1;
                                state <= DRAW_A;
                            end else begin
                                deal_err <= 1'b1;
                            end
                        end
                    end
                    DRAW_A: begin
                        if (count[probe] != 3'd0) begin
                            count[probe] <= count[probe] - 3'd1;
                            card_a_next  <= probe;
                            left         <= left - 7'd1;
                            probe        <= cand;
                            state        <= DRAW_B;
                        end else begin
                            probe <= next_probe(probe);
                        end
                    end
                    DRAW_B: begin
                        if (count[probe] != 3'd0) begin
                            count[probe] <= count[probe] - 3'd1;
                            left         <= left - 7'd1;
                            card_a       <= card_a_next;
                            card_b       <= probe;
                            deal_valid   <= 1'b1;
                            busy         <= 1'b0;
                            state        <= DONE;
                        end else begin
                            probe <= next_probe(probe);
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
